// File: rtl/candy_mem_load_if.sv
// Load unit bus bundle: pipeline request channel, flush, SRAM read port
// and writeback result channel. The slave modport is the load unit's view;
// the master modport is the surrounding pipeline/SRAM/writeback side.
interface candy_mem_load_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int REG_AW = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [REG_AW-1:0] req_reg_addr;
    logic              flush;
    logic              sram_read_enable;
    logic [ADDR_W-1:0] sram_raddr;
    logic [DATA_W-1:0] sram_rdata;
    logic              load_valid;
    logic              load_ready;
    logic [REG_AW-1:0] load_reg_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_err;

    modport slave (
        input  req_valid, req_addr, req_reg_addr, flush, sram_rdata, load_ready,
        output req_ready, sram_read_enable, sram_raddr,
               load_valid, load_reg_addr, load_data, load_err
    );

    modport master (
        output req_valid, req_addr, req_reg_addr, flush, sram_rdata, load_ready,
        input  req_ready, sram_read_enable, sram_raddr,
               load_valid, load_reg_addr, load_data, load_err
    );
endinterface

// File: rtl/candy_mem_load.sv
// Load unit: accepts one load request, strobes a single SRAM read, waits the
// fixed read latency, and hands the tagged result to writeback over a
// valid/ready handshake. Out-of-range addresses return an error result
// without touching the SRAM. A flush while a read is in flight drains the
// pending response so a stale word can never be presented later.
module candy_mem_load #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int REG_AW    = 5,
    parameter int RD_LAT    = 2,
    parameter int MEM_DEPTH = 65536
) (
    input logic             clk,
    input logic             rst,
    candy_mem_load_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    localparam logic [3:0]        LAT_CNT   = 4'(RD_LAT);
    localparam logic [DATA_W-1:0] ZERO_DATA = '0;

    state_t     state;
    logic [3:0] cnt;

    // Address check done on a widened compare so MEM_DEPTH == 2**ADDR_W works.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return (33'(a) < 33'(MEM_DEPTH));
    endfunction

    // Ready only while idle and out of reset.
    assign bus.req_ready = rst & (state == S_IDLE);

    // Load FSM with registered SRAM strobe and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= S_IDLE;
            cnt                  <= 4'd0;
            bus.sram_read_enable <= 1'b0;
            bus.sram_raddr       <= {ADDR_W{1'b0}};
            bus.load_valid       <= 1'b0;
            bus.load_reg_addr    <= {REG_AW{1'b0}};
            bus.load_data        <= ZERO_DATA;
            bus.load_err         <= 1'b0;
        end else begin
            bus.sram_read_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid && !bus.flush) begin
                        bus.load_reg_addr <= bus.req_reg_addr;
                        if (addr_in_range(bus.req_addr)) begin
                            bus.sram_read_enable <= 1'b1;
                            bus.sram_raddr       <= bus.req_addr;
                            state                <= S_ISSUE;
                        end else begin
                            // Error result goes straight to writeback, no SRAM access.
                            bus.load_err   <= 1'b1;
                            bus.load_data  <= ZERO_DATA;
                            bus.load_valid <= 1'b1;
                            state          <= S_HOLD;
                        end
                    end
                end
                S_ISSUE: begin
                    // The read is already strobed, so a flush must still absorb it.
                    cnt   <= LAT_CNT;
                    state <= bus.flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (cnt <= 4'd1) begin
                        cnt <= 4'd0;
                        if (bus.flush) begin
                            state <= S_IDLE;
                        end else begin
                            bus.load_data  <= bus.sram_rdata;
                            bus.load_err   <= 1'b0;
                            bus.load_valid <= 1'b1;
                            state          <= S_HOLD;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (bus.flush) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_HOLD: begin
                    // Flush wins over a same-edge handshake: result is not delivered.
                    if (bus.flush || bus.load_ready) begin
                        bus.load_valid <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (cnt <= 4'd1) begin
                        cnt   <= 4'd0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_candy_mem_load.sv
// Bench for candy_mem_load: directed scenarios followed by random traffic,
// checked against a transaction-level model through a scoreboard queue.
module tb_candy_mem_load;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 16;
    localparam int REG_AW    = 5;
    localparam int RD_LAT    = 2;
    localparam int MEM_DEPTH = 1024;

    typedef struct {
        logic [REG_AW-1:0] reg_a;
        logic [DATA_W-1:0] data;
        logic              err;
        int                acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t              q[$];
    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
    int                exp_strobe_cyc = -1;
    logic [ADDR_W-1:0] exp_addr = '0;
    int                last_strobe = -100;
    bit                st_en   [16];
    logic [ADDR_W-1:0] st_addr [16];

    candy_mem_load_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) bus ();

    candy_mem_load #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW),
        .RD_LAT(RD_LAT), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    // SRAM model: checks strobes and returns mem[addr] RD_LAT cycles after a strobe, junk otherwise.
    always @(negedge clk) begin : sram_p
        int k;
        if (bus.sram_read_enable) begin
            check(cyc == exp_strobe_cyc, "strobe_cycle", longint'(cyc), longint'(exp_strobe_cyc));
            check(bus.sram_raddr == exp_addr, "strobe_addr", longint'(bus.sram_raddr), longint'(exp_addr));
            st_en[cyc[3:0]]   = 1'b1;
            st_addr[cyc[3:0]] = bus.sram_raddr;
            last_strobe       = cyc;
        end else begin
            st_en[cyc[3:0]] = 1'b0;
            if (rst && cyc == exp_strobe_cyc)
                check(bus.sram_read_enable, "strobe_missing", longint'(bus.sram_read_enable), 1);
        end
        k = cyc - RD_LAT;
        if (k >= 0 && st_en[k[3:0]])
            bus.sram_rdata = mem[st_addr[k[3:0]][9:0]];
        else
            bus.sram_rdata = $urandom;
    end

    // Acceptance: push the expected result when a request is taken.
    always @(negedge clk) begin : acc_p
        exp_t e;
        if (rst && bus.req_valid && bus.req_ready && !bus.flush) begin
            e.reg_a = bus.req_reg_addr;
            e.acc   = cyc;
            if ({16'b0, bus.req_addr} < 32'(MEM_DEPTH)) begin
                e.err          = 1'b0;
                e.data         = mem[bus.req_addr[9:0]];
                exp_strobe_cyc = cyc + 1;
                exp_addr       = bus.req_addr;
            end else begin
                e.err  = 1'b1;
                e.data = '0;
            end
            q.push_back(e);
        end
    end

    // Monitor: result timing, contents, delivery and flush discard.
    always @(negedge clk) begin : mon_p
        int due;
        if (rst) begin
            if (q.size() > 0) begin
                due = q[0].acc + (q[0].err ? 1 : RD_LAT + 2);
                if (bus.load_valid || cyc >= due)
                    check(bus.load_valid == (cyc >= due), "valid_timing",
                          longint'(bus.load_valid), longint'(cyc >= due));
                if (bus.load_valid) begin
                    check(bus.load_reg_addr == q[0].reg_a, "load_reg_addr",
                          longint'(bus.load_reg_addr), longint'(q[0].reg_a));
                    check(bus.load_data == q[0].data, "load_data",
                          longint'(bus.load_data), longint'(q[0].data));
                    check(bus.load_err == q[0].err, "load_err",
                          longint'(bus.load_err), longint'(q[0].err));
                    if (bus.load_ready && !bus.flush) void'(q.pop_front());
                end
            end else begin
                check(!bus.load_valid, "unexpected_valid", longint'(bus.load_valid), 0);
            end
            if (bus.flush) q.delete();
        end
    end

    // Ready model: free when out of reset, nothing pending and no read still in flight.
    always @(posedge clk) begin
        #1;
        check(bus.req_ready == (rst && q.size() == 0 && cyc > last_strobe + RD_LAT), "req_ready",
              longint'(bus.req_ready), longint'(rst && q.size() == 0 && cyc > last_strobe + RD_LAT));
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [REG_AW-1:0] r);
        bit done = 1'b0;
        @(posedge clk); #1;
        bus.req_valid    = 1'b1;
        bus.req_addr     = a;
        bus.req_reg_addr = r;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready && !bus.flush) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check(done, "accept_timeout", longint'(done), 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic check_outputs_zero();
        check(!bus.req_ready, "rst_req_ready", longint'(bus.req_ready), 0);
        check(!bus.sram_read_enable, "rst_sram_en", longint'(bus.sram_read_enable), 0);
        check(bus.sram_raddr == '0, "rst_sram_raddr", longint'(bus.sram_raddr), 0);
        check(!bus.load_valid, "rst_load_valid", longint'(bus.load_valid), 0);
        check(bus.load_reg_addr == '0, "rst_load_reg", longint'(bus.load_reg_addr), 0);
        check(bus.load_data == '0, "rst_load_data", longint'(bus.load_data), 0);
        check(!bus.load_err, "rst_load_err", longint'(bus.load_err), 0);
    endtask

    task automatic async_reset_mid();
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_outputs_zero();
        q.delete();
        exp_strobe_cyc = -1;
        last_strobe    = -100;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        bit got;
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
        mem[16] = 32'hDEADBEEF;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_reg_addr = '0;
        bus.flush        = 1'b0;
        bus.load_ready   = 1'b1;
        bus.sram_rdata   = '0;

        #2 rst = 1'b0;
        #2 check_outputs_zero();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Single load with the result taken immediately.
        send(16'h0010, 5'd5);
        idle(6);

        // Back-pressure: result held while writeback stalls.
        bus.load_ready = 1'b0;
        send(16'h0020, 5'd3);
        idle(10);
        bus.load_ready = 1'b1;
        idle(3);

        // Out-of-range request.
        send(16'h0400, 5'd7);
        idle(3);

        // Flush during WAIT, then a fresh load.
        send(16'h0030, 5'd1);
        @(posedge clk); #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        send(16'h0040, 5'd2);
        idle(6);

        // Flush during ISSUE.
        send(16'h0050, 5'd4);
        bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        idle(5);

        // Flush during HOLD with load_ready high on the same edge.
        send(16'h0060, 5'd6);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = bus.load_valid;
        end
        check(got, "hold_wait_timeout", longint'(got), 1);
        @(posedge clk); #1;
        bus.flush      = 1'b1;
        bus.load_ready = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        idle(3);

        // Flush in IDLE blocks acceptance.
        bus.req_valid    = 1'b1;
        bus.req_addr     = 16'h0070;
        bus.req_reg_addr = 5'd9;
        bus.flush        = 1'b1;
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        idle(3);

        // Async reset mid-WAIT, then a normal load.
        send(16'h0080, 5'd8);
        async_reset_mid();
        send(16'h0090, 5'd10);
        idle(6);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            bus.req_valid    = 1'($urandom_range(0, 1));
            bus.req_addr     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1024, 65535))
                                                           : 16'($urandom_range(0, 1023));
            bus.req_reg_addr = 5'($urandom);
            bus.flush        = ($urandom_range(0, 19) == 0);
            bus.load_ready   = ($urandom_range(0, 3) != 0);
        end

        bus.req_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.load_ready = 1'b1;
        idle(20);
        check(q.size() == 0, "drain_empty", longint'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/candy_mem_load.md
Name: candy_mem_load

Overview:
- Load unit: the read-side counterpart of the writeback stage.
- Accepts one load request (SRAM address plus destination register) from the pipeline, issues a single SRAM read and waits a fixed SRAM read latency.
- Captures the read data and presents it, tagged with the destination register, to writeback over a valid/ready handshake.
- One outstanding request. Supports flush and out-of-range address detection.

Parameters:
- DATA_W, 32, SRAM data and register data width.
- ADDR_W, 16, SRAM address width.
- REG_AW, 5, register address width.
- RD_LAT, 2, SRAM read latency in cycles; legal range 1..15.
- MEM_DEPTH, 65536, number of valid SRAM words; an address >= MEM_DEPTH is out of range.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_W  SRAM word address to load.
- req_reg_addr  in  REG_AW  destination register.
- flush  in  1  discard any in-flight or held load.
- sram_read_enable  out  1  SRAM read strobe.
- sram_raddr  out  ADDR_W  SRAM read address.
- sram_rdata  in  DATA_W  SRAM read data.
- load_valid  out  1  load result present.
- load_ready  in  1  writeback accepts the result.
- load_reg_addr  out  REG_AW  destination register of the result.
- load_data  out  DATA_W  loaded data.
- load_err  out  1  result is an out-of-range error; load_data is 0.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; counter cleared.
  - sram_read_enable, sram_raddr, load_valid, load_reg_addr, load_data and load_err all 0.
  - req_ready forced 0 while rst is low.
- req_ready = 1 exactly when state is IDLE and rst is high (combinational from state). Acceptance occurs when req_valid & req_ready are high at a rising edge.
- States:
  - IDLE:
    - Accept, in range: latch addr and reg_addr, go to ISSUE.
    - Accept, out of range: latch reg_addr, set load_err=1 and load_data=0, go to HOLD. No SRAM access.
  - ISSUE (exactly 1 cycle):
    - sram_read_enable=1 and sram_raddr=latched addr; both registered outputs, stable for the whole cycle.
    - Load counter with RD_LAT, go to WAIT.
    - In every other state sram_read_enable=0 and sram_raddr holds its last value.
  - WAIT:
    - Counter decrements each cycle.
    - sram_rdata is valid in the cycle RD_LAT cycles after the ISSUE cycle. It is captured into load_data at the end of that cycle (counter==1), with load_err=0; then go to HOLD.
  - HOLD:
    - load_valid=1; load_reg_addr, load_data and load_err stable until handshake.
    - On load_valid & load_ready: load_valid drops next cycle, go to IDLE.
  - DRAIN (flushed in-flight read):
    - Continue counting; discard sram_rdata at counter==1 (load_data unchanged, load_valid stays 0); go to IDLE.
- Latency:
  - Request accepted in cycle a gives ISSUE in cycle a+1 and load_valid high from cycle a+RD_LAT+2.
  - With load_ready held high, the next request is accepted in cycle a+RD_LAT+3.
  - Out-of-range request: load_valid from cycle a+1.
- Flush (sampled at the rising edge, wins over all other events that edge):
  - IDLE: blocks acceptance that edge.
  - ISSUE or WAIT: go to DRAIN. A read already strobed must still be absorbed so a stale SRAM response is never presented.
  - HOLD: drop load_valid, go to IDLE, even if load_ready is high the same edge (the result is not considered delivered).
  - DRAIN: no effect.
- Back-pressure: load_ready low in HOLD stalls indefinitely; outputs are held and no new request is accepted.
- Reset mid-operation: immediate return to IDLE; any pending SRAM response is ignored after reset release.
- Counter is 4 bits. RD_LAT=1 means WAIT lasts 1 cycle.

Test Plan:
- Single load, RD_LAT=2: req addr 0x0010, reg 5, accepted cycle 0; SRAM returns 0xDEADBEEF in cycle 3 -> sram_read_enable=1 only in cycle 1 with raddr 0x0010; load_valid from cycle 4 with reg 5, data 0xDEADBEEF, err 0; req_ready=0 in cycles 1-4.
- Back-pressure: load_ready low for 5 cycles after load_valid -> outputs stable, req_ready stays 0; handshake at cycle 9 -> load_valid 0 and req_ready 1 in cycle 10.
- Out of range, MEM_DEPTH=1024: req addr 0x0400, reg 7 -> no SRAM strobe; load_valid next cycle with err 1, data 0, reg 7.
- Flush during WAIT: flush in cycle 2 of a load -> no load_valid; cycle-3 rdata discarded; req_ready=1 in cycle 4; the following load returns its own data, not the stale value.
- Flush during HOLD with load_ready high the same edge -> load_valid drops, state IDLE; the result is not counted as delivered.
- Async reset asserted mid-WAIT between clock edges -> all outputs 0 immediately; after release req_ready=1 and a new load completes normally.
